// File: rtl/cooktime_bcd_counter.sv
// cooktime_bcd_counter
// Cook-time setter and countdown timer for the egg timer. Holds a packed-BCD
// time value that the user adjusts with up/down buttons (with hold-to-repeat)
// while in SET. The start button runs a countdown of one step per TICK_DIV
// enabled clocks and pauses or resumes it. The design raises done at zero and
// holds it until any button press acknowledges it.
//
// Ports
//   clk           system clock (10 Hz nominal)
//   reset         synchronous, active-high; overrides main_enable
//   main_enable   global enable; low freezes value, state and counters
//   button_up     increment request (level, debounced, synchronous)
//   button_dn     decrement request (level, debounced, synchronous)
//   button_start  start / pause / resume / acknowledge (level)
//   digits        packed BCD value, [3:0]=ones, [7:4]=tens, ...
//   running       high while counting down
//   paused        high while paused
//   done          high once the countdown has reached zero, until acknowledged

module cooktime_bcd_counter #(
    parameter int DIGITS       = 2,
    parameter int MAX_VALUE    = 99,
    parameter int WRAP         = 1,
    parameter int TICK_DIV     = 10,
    parameter int REPEAT_DELAY = 10,
    parameter int REPEAT_RATE  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                main_enable,
    input  logic                button_up,
    input  logic                button_dn,
    input  logic                button_start,
    output logic [4*DIGITS-1:0] digits,
    output logic                running,
    output logic                paused,
    output logic                done
);

    localparam int W  = 4 * DIGITS;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

    typedef enum logic [1:0] {
        ST_SET,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    // Decimal to packed BCD, used only to build the MAX_VALUE constant.
    function automatic logic [W-1:0] to_bcd(input int value);
        logic [W-1:0] r;
        int           v;
        r = '0;
        v = value;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // BCD +1 with the carry rippling digit by digit.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (r[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // BCD -1 with the borrow rippling digit by digit.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VALUE);

    state_t         state_q,   state_d;
    logic [W-1:0]   value_q,   value_d;
    logic [TW-1:0]  tick_q,    tick_d;
    logic [HW-1:0]  hold_q,    hold_d;
    logic           up_q,      dn_q,   start_q;
    logic           running_q, paused_q, done_q;

    logic           up_edge, dn_edge, start_edge;
    logic [HW-1:0]  hold_cur;
    logic           step;
    logic [W-1:0]   value_up, value_dn, value_tick;

    // Edges are dropped outright while disabled; the history regs still
    // track the buttons so re-enabling with a button held is not an edge.
    assign up_edge    = main_enable & button_up    & ~up_q;
    assign dn_edge    = main_enable & button_dn    & ~dn_q;
    assign start_edge = main_enable & button_start & ~start_q;

    // Bounded SET adjustments: wrap or saturate at 0 / MAX_VALUE.
    assign value_up   = (value_q == MAX_BCD) ? ((WRAP != 0) ? '0 : MAX_BCD)
                                             : bcd_inc(value_q);
    assign value_dn   = (value_q == '0)      ? ((WRAP != 0) ? MAX_BCD : '0)
                                             : bcd_dec(value_q);
    // Countdown step never wraps; it is only taken while the value is nonzero.
    assign value_tick = bcd_dec(value_q);

    // Next-state logic for the whole timer.
    // The hold counter is rewound to REPEAT_DELAY on every auto-repeat,
    // so it stays bounded while giving steps at DELAY, DELAY+RATE, ...
    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        tick_d   = tick_q;
        hold_d   = hold_q;
        hold_cur = '0;
        step     = 1'b0;

        if (main_enable) begin
            case (state_q)
                ST_SET: begin
                    if (start_edge && (value_q != '0)) begin
                        state_d = ST_RUN;
                        tick_d  = '0;
                        hold_d  = '0;
                    end else if (button_up && button_dn) begin
                        hold_d = '0;
                    end else if (button_up || button_dn) begin
                        hold_cur = (up_edge || dn_edge) ? '0 : hold_q + HW'(1);
                        step     = (hold_cur == '0)
                                || (hold_cur == HW'(REPEAT_DELAY))
                                || (hold_cur == HW'(REPEAT_DELAY + REPEAT_RATE));
                        hold_d   = (step && (hold_cur != '0)) ? HW'(REPEAT_DELAY)
                                                             : hold_cur;
                        if (step) begin
                            value_d = button_up ? value_up : value_dn;
                        end
                    end else begin
                        hold_d = '0;
                    end
                end

                ST_RUN: begin
                    hold_d = '0;
                    if (tick_q == TW'(TICK_DIV - 1)) begin
                        tick_d  = '0;
                        value_d = value_tick;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                    // A decrement reaching zero wins over a simultaneous pause.
                    if ((tick_q == TW'(TICK_DIV - 1)) && (value_tick == '0)) begin
                        state_d = ST_DONE;
                    end else if (start_edge) begin
                        state_d = ST_PAUSE;
                    end
                end

                ST_PAUSE: begin
                    if (start_edge) begin
                        state_d = ST_RUN;
                    end else if (up_edge || dn_edge) begin
                        state_d = ST_SET;
                        hold_d  = '0;
                    end
                end

                ST_DONE: begin
                    if (up_edge || dn_edge || start_edge) begin
                        state_d = ST_SET;
                        value_d = '0;
                        hold_d  = '0;
                    end
                end

                default: begin
                    state_d = ST_SET;
                end
            endcase
        end
    end

    // State, counters, button history and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_SET;
            value_q   <= '0;
            tick_q    <= '0;
            hold_q    <= '0;
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
            start_q   <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            tick_q    <= tick_d;
            hold_q    <= hold_d;
            up_q      <= button_up;
            dn_q      <= button_dn;
            start_q   <= button_start;
            running_q <= (state_d == ST_RUN);
            paused_q  <= (state_d == ST_PAUSE);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign digits  = value_q;
    assign running = running_q;
    assign paused  = paused_q;
    assign done    = done_q;

endmodule

// File: tb/tb_cooktime_bcd_counter.sv
// tb_cooktime_bcd_counter
// Directed bench for cooktime_bcd_counter. Two instances share all inputs:
// dut_wrap uses default parameters (WRAP=1), dut_sat uses WRAP=0 and is only
// examined around the bound tests. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a period from the active edge.

module tb_cooktime_bcd_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       main_enable = 1'b1;
    logic       button_up = 1'b0;
    logic       button_dn = 1'b0;
    logic       button_start = 1'b0;

    logic [7:0] digits_wrap, digits_sat;
    logic       running_wrap, paused_wrap, done_wrap;
    logic       running_sat, paused_sat, done_sat;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cooktime_bcd_counter dut_wrap (
        .clk          (clk),
        .reset        (reset),
        .main_enable  (main_enable),
        .button_up    (button_up),
        .button_dn    (button_dn),
        .button_start (button_start),
        .digits       (digits_wrap),
        .running      (running_wrap),
        .paused       (paused_wrap),
        .done         (done_wrap)
    );

    cooktime_bcd_counter #(.WRAP(0)) dut_sat (
        .clk          (clk),
        .reset        (reset),
        .main_enable  (main_enable),
        .button_up    (button_up),
        .button_dn    (button_dn),
        .button_start (button_start),
        .digits       (digits_sat),
        .running      (running_sat),
        .paused       (paused_sat),
        .done         (done_sat)
    );

    // Drive one cycle of inputs and return at the next falling edge.
    task automatic applyStimulus(input logic rst, input logic en,
                                 input logic up, input logic dn,
                                 input logic st);
        reset        = rst;
        main_enable  = en;
        button_up    = up;
        button_dn    = dn;
        button_start = st;
        @(negedge clk);
    endtask

    // Let further cycles pass with the inputs unchanged.
    task automatic stepCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One press of one clock followed by one clock released.
    task automatic pressButton(input logic up, input logic dn, input logic st);
        applyStimulus(1'b0, 1'b1, up, dn, st);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Digits plus flags {running, paused, done} of the default instance.
    task automatic checkState(input string tag, input logic [7:0] exp_digits,
                              input logic [2:0] exp_flags);
        checkOutput({tag, "_digits"}, digits_wrap, exp_digits);
        checkOutput({tag, "_flags"},
                    {5'b0, running_wrap, paused_wrap, done_wrap},
                    {5'b0, exp_flags});
    endtask

    initial begin
        $display("[TB] start");

        // Reset state.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkState("reset", 8'h00, 3'b000);

        // Short presses below the repeat delay each give exactly one step.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            stepCycles(3);
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        checkState("short_presses", 8'h05, 3'b000);

        // Disabled press is dropped; re-enabling while held is not an edge.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        stepCycles(1);
        checkState("en_low_press", 8'h05, 3'b000);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkState("reenable_held", 8'h05, 3'b000);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Hold-to-repeat: steps at hold counts 0, 10, 13, 16.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkState("hold_first", 8'h01, 3'b000);
        stepCycles(9);
        checkState("hold_cnt9", 8'h01, 3'b000);
        stepCycles(1);
        checkState("hold_cnt10", 8'h02, 3'b000);
        stepCycles(6);
        checkState("hold_cnt16", 8'h04, 3'b000);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkState("hold_release", 8'h04, 3'b000);
        pressButton(1'b0, 1'b1, 1'b0);
        checkState("hold_then_dn", 8'h03, 3'b000);

        // Both buttons high: no change.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkState("both_buttons", 8'h03, 3'b000);

        // Lower bound: wrap vs saturate.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        pressButton(1'b0, 1'b1, 1'b0);
        checkOutput("wrap_dn_at_0", digits_wrap, 8'h99);
        checkOutput("sat_dn_at_0", digits_sat, 8'h00);

        // Upper bound: wrap vs saturate.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 99; i++) pressButton(1'b1, 1'b0, 1'b0);
        checkOutput("wrap_count_99", digits_wrap, 8'h99);
        checkOutput("sat_count_99", digits_sat, 8'h99);
        pressButton(1'b1, 1'b0, 1'b0);
        checkOutput("wrap_up_at_99", digits_wrap, 8'h00);
        checkOutput("sat_up_at_99", digits_sat, 8'h99);

        // BCD carry and borrow across the digit boundary.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) pressButton(1'b1, 1'b0, 1'b0);
        checkState("bcd_09", 8'h09, 3'b000);
        pressButton(1'b1, 1'b0, 1'b0);
        checkState("bcd_carry", 8'h10, 3'b000);
        pressButton(1'b0, 1'b1, 1'b0);
        checkState("bcd_borrow", 8'h09, 3'b000);

        // Countdown from 02 to done, then acknowledge.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        pressButton(1'b1, 1'b0, 1'b0);
        pressButton(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkState("run_start", 8'h02, 3'b100);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        stepCycles(8);
        checkState("run_cycle9", 8'h02, 3'b100);
        stepCycles(1);
        checkState("run_cycle10", 8'h01, 3'b100);
        stepCycles(9);
        checkState("run_cycle19", 8'h01, 3'b100);
        stepCycles(1);
        checkState("run_done", 8'h00, 3'b001);
        stepCycles(3);
        checkState("done_holds", 8'h00, 3'b001);
        pressButton(1'b0, 1'b0, 1'b1);
        checkState("done_ack", 8'h00, 3'b000);

        // Pause, disable for 7 cycles, resume: 10 enabled RUN cycles per step.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) pressButton(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        stepCycles(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkState("pause_at_5", 8'h03, 3'b010);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycles(6);
        checkState("pause_disabled", 8'h03, 3'b010);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkState("resume", 8'h03, 3'b100);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        stepCycles(3);
        checkState("resume_cycle4", 8'h03, 3'b100);
        stepCycles(1);
        checkState("resume_cycle5", 8'h02, 3'b100);

        // Pause, then an up edge returns to SET keeping the value unadjusted.
        pressButton(1'b0, 1'b0, 1'b1);
        checkState("pause_again", 8'h02, 3'b010);
        pressButton(1'b1, 1'b0, 1'b0);
        checkState("pause_to_set", 8'h02, 3'b000);

        // Start with value 00 is ignored.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        pressButton(1'b0, 1'b0, 1'b1);
        checkState("start_at_zero", 8'h00, 3'b000);

        // Reset in the middle of a run at 37.
        for (int i = 0; i < 37; i++) pressButton(1'b1, 1'b0, 1'b0);
        checkState("set_37", 8'h37, 3'b000);
        pressButton(1'b0, 1'b0, 1'b1);
        stepCycles(3);
        checkState("run_37", 8'h37, 3'b100);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkState("reset_mid_run", 8'h00, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
